inst_fetch_req: RTL and testbench

- Fetch front end of the core: owns the PC and issues instruction-read requests to instruction memory over a valid/ready request channel.
- Collects returning responses and presents them in program order as instruction/address pairs to the IF/ID pipeline register.
- Handles pipeline hold and jump/flush by stalling issue and discarding stale in-flight responses.

---
 rtl/inst_fetch_req.sv | 143 ++++++++++++++
 tb/tb_inst_fetch_req.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_req.sv
// Instruction fetch front end: owns the PC, issues word reads over a valid/ready channel,
// and returns in-order {addr, data} pairs to IF/ID while discarding responses made stale by jumps.
module inst_fetch_req #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                MAX_OUT    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        hold_flag_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic [ADDR_W-1:0] req_addr_o,
  input  logic              rsp_valid_i,
  input  logic [DATA_W-1:0] rsp_data_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o
);

  localparam int                DEPTH    = 4;
  localparam logic [1:0]        LAST_IDX = 2'(MAX_OUT - 1);
  localparam logic [3:0]        CREDITS  = 4'(MAX_OUT);
  localparam logic [DATA_W-1:0] NOP      = DATA_W'(32'h0000_0013);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] lastAddr_q, lastAddr_d;
  logic [2:0]        outCnt_q, outCnt_d;
  logic [2:0]        killCnt_q, killCnt_d;
  logic [2:0]        bufCnt_q, bufCnt_d;
  logic [1:0]        fifoWr_q, fifoWr_d, fifoRd_q, fifoRd_d;
  logic [1:0]        bufWr_q, bufWr_d, bufRd_q, bufRd_d;
  logic [ADDR_W-1:0] addrFifo_q [DEPTH];
  logic [ADDR_W-1:0] addrFifo_d [DEPTH];
  logic [ADDR_W-1:0] bufAddr_q  [DEPTH];
  logic [ADDR_W-1:0] bufAddr_d  [DEPTH];
  logic [DATA_W-1:0] bufData_q  [DEPTH];
  logic [DATA_W-1:0] bufData_d  [DEPTH];

  logic [3:0] creditsUsed;
  logic       issue, rspKill, rspTake, consume;

  function automatic logic [1:0] incPtr(input logic [1:0] p);
    return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit check uses only registered counts, so rsp_valid_i never reaches req_valid_o combinationally.
  assign creditsUsed = {1'b0, outCnt_q} + {1'b0, bufCnt_q} + {1'b0, killCnt_q};
  assign req_valid_o = !rst_i && !jump_flag_i && (hold_flag_i == 3'd0) && (creditsUsed < CREDITS);
  assign req_addr_o  = pc_q;

  assign issue   = req_valid_o && req_ready_i;
  assign rspKill = rsp_valid_i && (killCnt_q != 3'd0);
  assign rspTake = rsp_valid_i && (killCnt_q == 3'd0) && (outCnt_q != 3'd0);

  assign inst_valid_o = (bufCnt_q != 3'd0);
  assign inst_o       = inst_valid_o ? bufData_q[bufRd_q] : NOP;
  assign inst_addr_o  = inst_valid_o ? bufAddr_q[bufRd_q] : lastAddr_q;
  assign consume      = inst_valid_o && (hold_flag_i < 3'd2);

  always_comb begin
    pc_d       = pc_q;
    outCnt_d   = outCnt_q;
    killCnt_d  = killCnt_q;
    bufCnt_d   = bufCnt_q;
    fifoWr_d   = fifoWr_q;
    fifoRd_d   = fifoRd_q;
    bufWr_d    = bufWr_q;
    bufRd_d    = bufRd_q;
    addrFifo_d = addrFifo_q;
    bufAddr_d  = bufAddr_q;
    bufData_d  = bufData_q;
    lastAddr_d = inst_valid_o ? bufAddr_q[bufRd_q] : lastAddr_q;

    if (jump_flag_i) begin
      // A live response landing in the jump cycle is stale too, so it is dropped instead of becoming a kill.
      pc_d      = {jump_addr_i[ADDR_W-1:2], 2'b00};
      outCnt_d  = 3'd0;
      killCnt_d = killCnt_q + outCnt_q - 3'(rspKill) - 3'(rspTake);
      bufCnt_d  = 3'd0;
      fifoWr_d  = 2'd0;
      fifoRd_d  = 2'd0;
      bufWr_d   = 2'd0;
      bufRd_d   = 2'd0;
    end else begin
      killCnt_d = killCnt_q - 3'(rspKill);
      outCnt_d  = outCnt_q + 3'(issue) - 3'(rspTake);
      bufCnt_d  = bufCnt_q + 3'(rspTake) - 3'(consume);
      if (issue) begin
        pc_d                 = pc_q + ADDR_W'(4);
        addrFifo_d[fifoWr_q] = pc_q;
        fifoWr_d             = incPtr(fifoWr_q);
      end
      if (rspTake) begin
        bufAddr_d[bufWr_q] = addrFifo_q[fifoRd_q];
        bufData_d[bufWr_q] = rsp_data_i;
        fifoRd_d           = incPtr(fifoRd_q);
        bufWr_d            = incPtr(bufWr_q);
      end
      if (consume) begin
        bufRd_d = incPtr(bufRd_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_ADDR;
      lastAddr_q <= RESET_ADDR;
      outCnt_q   <= 3'd0;
      killCnt_q  <= 3'd0;
      bufCnt_q   <= 3'd0;
      fifoWr_q   <= 2'd0;
      fifoRd_q   <= 2'd0;
      bufWr_q    <= 2'd0;
      bufRd_q    <= 2'd0;
    end else begin
      pc_q       <= pc_d;
      lastAddr_q <= lastAddr_d;
      outCnt_q   <= outCnt_d;
      killCnt_q  <= killCnt_d;
      bufCnt_q   <= bufCnt_d;
      fifoWr_q   <= fifoWr_d;
      fifoRd_q   <= fifoRd_d;
      bufWr_q    <= bufWr_d;
      bufRd_q    <= bufRd_d;
    end
  end

  // Storage arrays need no reset: occupancy is governed entirely by the counters and pointers.
  always_ff @(posedge clk_i) begin
    addrFifo_q <= addrFifo_d;
    bufAddr_q  <= bufAddr_d;
    bufData_q  <= bufData_d;
  end

  rspProtocolA: assert property (@(posedge clk_i) disable iff (rst_i)
    !(rsp_valid_i && (outCnt_q == 3'd0) && (killCnt_q == 3'd0)));

endmodule

// File: tb/tb_inst_fetch_req.sv
// Randomized bench for inst_fetch_req: a latency-programmable memory model plus an in-order
// scoreboard of expected fetches, tagged by jump generation so stale responses are recognised.
module tb_inst_fetch_req;

  localparam int          MAX_OUT    = 2;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [2:0]  hold_flag_i = 3'd0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        req_valid_o;
  logic        req_ready_i = 1'b0;
  logic [31:0] req_addr_o;
  logic        rsp_valid_i = 1'b0;
  logic [31:0] rsp_data_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  inst_fetch_req #(
    .ADDR_W(32), .DATA_W(32), .RESET_ADDR(RESET_ADDR), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .hold_flag_i(hold_flag_i), .jump_flag_i(jump_flag_i),
    .jump_addr_i(jump_addr_i), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_addr_o(req_addr_o), .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          gen;
    int          due;
  } memEntry_t;

  memEntry_t   memQ[$];
  logic [31:0] expQ[$];
  int          bufModel = 0;
  int          gen = 0;
  int          cycle = 0;
  logic [31:0] modelPc = RESET_ADDR;
  logic [31:0] lastAddr = RESET_ADDR;
  int          checks = 0;
  int          failures = 0;

  int          lat = 1, readyPct = 100, holdSel = 0, jumpPct = 0, rstPct = 100;
  bit          jumpOnce = 0;
  logic [31:0] jumpOnceAddr = '0;

  function automatic logic [31:0] dataOf(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0000;
  endfunction

  function automatic bit modelReqValid();
    return !rst_i && !jump_flag_i && (hold_flag_i == 3'd0) && ((memQ.size() + bufModel) < MAX_OUT);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  task automatic setKnobs(input int l, input int rdy, input int hs, input int jp, input int rp);
    lat = l; readyPct = rdy; holdSel = hs; jumpPct = jp; rstPct = rp;
  endtask

  task automatic checkCycle();
    bit expValid;
    expValid = modelReqValid();
    checkOutput("req_valid", 32'(req_valid_o), 32'(expValid));
    if (expValid) checkOutput("req_addr", req_addr_o, modelPc);
    checkOutput("inst_valid", 32'(inst_valid_o), 32'(bufModel > 0));
    checkOutput("inst", inst_o, (bufModel > 0) ? dataOf(expQ[0]) : NOP);
    checkOutput("inst_addr", inst_addr_o, (bufModel > 0) ? expQ[0] : lastAddr);
  endtask

  // Advances the model across the upcoming rising edge, using the stimulus currently applied.
  task automatic updateModel();
    bit        handshake, arrived;
    memEntry_t e;
    handshake = modelReqValid() && req_ready_i;
    if (rst_i) begin
      modelPc  = RESET_ADDR;
      lastAddr = RESET_ADDR;
      memQ.delete();
      expQ.delete();
      bufModel = 0;
      return;
    end
    arrived = 0;
    if (rsp_valid_i) begin
      e = memQ.pop_front();
      arrived = (e.gen == gen);
    end
    if (bufModel > 0) lastAddr = expQ[0];
    if (jump_flag_i) begin
      modelPc  = {jump_addr_i[31:2], 2'b00};
      expQ.delete();
      bufModel = 0;
      gen++;
    end else begin
      if (bufModel > 0 && hold_flag_i < 3'd2) begin
        void'(expQ.pop_front());
        bufModel--;
      end
      if (arrived) bufModel++;
      if (handshake) begin
        e.addr = modelPc;
        e.gen  = gen;
        e.due  = cycle + lat;
        memQ.push_back(e);
        expQ.push_back(modelPc);
        modelPc = modelPc + 32'd4;
      end
    end
  endtask

  task automatic applyStimulus(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_i = ($urandom_range(99) < rstPct);
      if (holdSel < 0) begin
        r = $urandom_range(7);
        hold_flag_i = (r < 5) ? 3'd0 : 3'(r - 4);
      end else begin
        hold_flag_i = 3'(holdSel);
      end
      jump_flag_i = jumpOnce || ($urandom_range(99) < jumpPct);
      jump_addr_i = jumpOnce ? jumpOnceAddr : $urandom;
      jumpOnce    = 0;
      req_ready_i = ($urandom_range(99) < readyPct);
      if (memQ.size() > 0 && memQ[0].due <= cycle) begin
        rsp_valid_i = 1'b1;
        rsp_data_i  = dataOf(memQ[0].addr);
      end else begin
        rsp_valid_i = 1'b0;
        rsp_data_i  = $urandom;
      end
      @(negedge clk);
      checkCycle();
      updateModel();
      cycle++;
    end
  endtask

  initial begin
    $display("[TB] starting inst_fetch_req bench");
    setKnobs(1, 100, 0, 0, 100); applyStimulus(3);
    // Streaming with a one-cycle memory.
    setKnobs(1, 100, 0, 0, 0);   applyStimulus(20);
    // Request channel stalled, then released.
    setKnobs(1, 0, 0, 0, 0);     applyStimulus(5);
    setKnobs(1, 100, 0, 0, 0);   applyStimulus(6);
    // ID hold freezes outputs and issue.
    setKnobs(1, 100, 3, 0, 0);   applyStimulus(4);
    setKnobs(1, 100, 0, 0, 0);   applyStimulus(8);
    // PC hold stops issue while the buffer drains.
    setKnobs(1, 100, 1, 0, 0);   applyStimulus(6);
    setKnobs(1, 100, 0, 0, 0);   applyStimulus(5);
    // Jump to an unaligned target with slow memory.
    setKnobs(3, 100, 0, 0, 0);   applyStimulus(4);
    jumpOnce = 1; jumpOnceAddr = 32'h0000_0103;
    applyStimulus(1);
    applyStimulus(14);
    // Reset with requests outstanding and the buffer full.
    setKnobs(3, 100, 3, 0, 0);   applyStimulus(6);
    setKnobs(3, 100, 3, 0, 100); applyStimulus(1);
    setKnobs(1, 100, 0, 0, 0);   applyStimulus(10);
    // Random mix of latency, back-pressure, holds, jumps and resets.
    for (int b = 0; b < 40; b++) begin
      setKnobs($urandom_range(1, 4), $urandom_range(30, 100), -1, 5, 1);
      applyStimulus(50);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
